// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - shared types, constants and arithmetic helpers for conv2d_stream
//
// Contents:
//   state_t     frame-control FSM states
//   KSIZE/NTAPS kernel geometry (3x3, 9 taps)
//   acc_width   accumulator width for given pixel/coefficient widths
//   saturate    clamp a 64-bit accumulator image to an out_w-bit range
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int KSIZE = 3;
  localparam int NTAPS = 9;

  // Nine full-width products need ceil(log2(9)) = 4 extra bits to sum exactly.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 4;
  endfunction

  // acc is the accumulator already extended to 64 bits (sign- or zero-extended
  // by the caller). Returns the clamped value in the low out_w bits.
  function automatic logic [63:0] saturate(input logic [63:0] acc,
                                           input int out_w,
                                           input bit is_signed,
                                           output logic sat);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = signed'(acc);
    if (is_signed) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end else begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end
    sat = 1'b0;
    if (v > hi) begin
      v   = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      v   = lo;
      sat = 1'b1;
    end
    return unsigned'(v);
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// rtl/conv2d_line_buffer.sv - enable-advanced shift delay of DEPTH samples
//
// Ports:
//   clk  rising-edge clock
//   en   advance the delay line by one sample
//   d    sample entering the line
//   q    sample that entered DEPTH advances ago (driven straight from a flop)
//
// Contents are not reset: stale samples only ever feed rows that produce no
// output, so clearing them would buy nothing.
module conv2d_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming 3x3 valid-mode convolution with saturation
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   coef_we/addr/data        coefficient write (honoured in IDLE only, k = 3*row+col)
//   start                    frame start request (IDLE only)
//   in_valid/in_ready/in_data   raster pixel stream in
//   out_valid/out_ready/out_data/out_sat   result stream out, out_sat = clamped
//   busy                     frame in progress
//   done                     one-cycle pulse after the last result is accepted
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [COEF_W-1:0] coef [NTAPS];

  logic accept;
  logic last_pix;
  logic gen;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign gen      = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign busy     = (state != IDLE);

  // lb0 yields pixel (r-1, c) and lb1 yields (r-2, c) for the pixel being accepted.
  logic [DATA_W-1:0] lb0_q, lb1_q;

  conv2d_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk (clk),
    .en  (accept),
    .d   (in_data),
    .q   (lb0_q)
  );

  conv2d_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk (clk),
    .en  (accept),
    .d   (lb0_q),
    .q   (lb1_q)
  );

  // Only the two older window columns are stored; the newest column is the
  // incoming triple itself, so the result can be registered on the accept edge.
  logic [DATA_W-1:0] win_a [KSIZE];
  logic [DATA_W-1:0] win_b [KSIZE];
  logic [DATA_W-1:0] new_col [KSIZE];

  assign new_col[0] = lb1_q;
  assign new_col[1] = lb0_q;
  assign new_col[2] = in_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KSIZE; i++) begin
        win_a[i] <= win_b[i];
        win_b[i] <= new_col[i];
      end
    end
  end

  logic [DATA_W-1:0] tap [NTAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  pe, ce;
  logic [OUT_W-1:0]  res_nxt;
  logic              sat_nxt;

  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      tap[KSIZE*i + 0] = win_a[i];
      tap[KSIZE*i + 1] = win_b[i];
      tap[KSIZE*i + 2] = new_col[i];
    end
    acc = '0;
    pe  = '0;
    ce  = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (SIGNED != 0) begin
        pe = {{(ACC_W-DATA_W){tap[k][DATA_W-1]}}, tap[k]};
        ce = {{(ACC_W-COEF_W){coef[k][COEF_W-1]}}, coef[k]};
      end else begin
        pe = {{(ACC_W-DATA_W){1'b0}}, tap[k]};
        ce = {{(ACC_W-COEF_W){1'b0}}, coef[k]};
      end
      // Truncating each product to ACC_W is exact in two's complement.
      acc = acc + pe * ce;
    end
    sat_nxt = 1'b0;
    res_nxt = OUT_W'(saturate({{(64-ACC_W){(SIGNED != 0) && acc[ACC_W-1]}}, acc},
                              OUT_W, SIGNED != 0, sat_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        coef[k] <= '0;
      end
    end else begin
      done <= (state == DRAIN) && out_valid && out_ready;

      if ((state == IDLE) && coef_we && (coef_addr < 4'(NTAPS))) begin
        coef[coef_addr] <= coef_data;
      end

      if ((state == IDLE) && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // in_ready guarantees a new result only lands when the old one leaves.
      if (accept && gen) begin
        out_valid <= 1'b1;
        out_data  <= res_nxt;
        out_sat   <= sat_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - directed scoreboard bench for conv2d_stream (5x5 frames)
module tb_conv2d_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic        in_ready_u, out_valid_u, out_sat_u, busy_u, done_u;
  logic [15:0] out_data_u;
  logic        in_ready_s, out_valid_s, out_sat_s, busy_s, done_s;
  logic [15:0] out_data_s;

  always #5 clk = ~clk;

  conv2d_stream #(.DATA_W(8), .COEF_W(8), .IMG_W(5), .IMG_H(5), .OUT_W(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_sat(out_sat_u), .busy(busy_u), .done(done_u)
  );

  conv2d_stream #(.DATA_W(8), .COEF_W(8), .IMG_W(5), .IMG_H(5), .OUT_W(16), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_sat(out_sat_s), .busy(busy_s), .done(done_s)
  );

  bit          use_s = 1'b0;
  logic        in_ready_c, out_valid_c, out_sat_c, busy_c, done_c;
  logic [15:0] out_data_c;

  assign in_ready_c  = use_s ? in_ready_s  : in_ready_u;
  assign out_valid_c = use_s ? out_valid_s : out_valid_u;
  assign out_sat_c   = use_s ? out_sat_s   : out_sat_u;
  assign out_data_c  = use_s ? out_data_s  : out_data_u;
  assign busy_c      = use_s ? busy_s      : busy_u;
  assign done_c      = use_s ? done_s      : done_u;

  logic [7:0]  pix [25];
  logic [7:0]  cf  [9];
  logic [16:0] exp_q [$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // Direct 3x3 valid-mode convolution of pixel (r,c) from the frame and kernel.
  task automatic push_expected(input int r, input int c);
    longint s, p, k, hi, lo;
    logic   sat;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p = use_s ? longint'($signed(pix[(r-2+i)*5 + (c-2+j)])) : longint'(pix[(r-2+i)*5 + (c-2+j)]);
        k = use_s ? longint'($signed(cf[3*i+j])) : longint'(cf[3*i+j]);
        s = s + p * k;
      end
    end
    hi  = use_s ? 32767 : 65535;
    lo  = use_s ? -32768 : 0;
    sat = 1'b0;
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
    exp_q.push_back({sat, s[15:0]});
  endtask

  task automatic load_coefs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 4'(k); coef_data = cf[k];
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Runs one frame; coefficient 8 is written in the start cycle when do_w8 is set.
  task automatic run_frame(input int stall_at, input int inject_at, input int abort_after, input bit do_w8);
    int sent, got, stall_hits;
    logic [16:0] e;
    logic [15:0] held;
    bit held_v;
    sent = 0; got = 0; stall_hits = 0; held = '0; held_v = 1'b0;
    @(negedge clk);
    coef_we = do_w8; coef_addr = 4'd8; coef_data = cf[8]; start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0; coef_we = 1'b0;
      out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      if (cyc == inject_at) begin
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'h07; start = 1'b1;
      end
      in_valid = (sent < 25);
      in_data  = (sent < 25) ? pix[sent] : 8'h00;
      #1;
      if (out_valid_c && !out_ready) begin
        stall_hits++;
        check("stall_in_ready", {31'd0, in_ready_c}, 32'd0);
        if (held_v) check("stall_data_stable", {16'd0, out_data_c}, {16'd0, held});
        held = out_data_c; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid_c && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {16'd0, out_data_c}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'd0, out_data_c}, {16'd0, e[15:0]});
          check("out_sat", {31'd0, out_sat_c}, {31'd0, e[16]});
        end
        got++;
      end
      if (in_valid && in_ready_c) begin
        if (sent / 5 >= 2 && sent % 5 >= 2) push_expected(sent / 5, sent % 5);
        sent++;
      end
      if (abort_after >= 0 && sent == abort_after) break;
      if (got == 9) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (abort_after < 0) begin
      check("frame_out_count", got, 9);
      check("scoreboard_empty", exp_q.size(), 0);
      if (stall_at >= 0) check("stall_cycles", stall_hits, 5);
      @(negedge clk);
      check("done_pulse", {31'd0, done_c}, 32'd1);
      check("busy_after", {31'd0, busy_c}, 32'd0);
      @(negedge clk);
      check("done_cleared", {31'd0, done_c}, 32'd0);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"},  {31'd0, in_ready_c},  32'd0);
    check({pfx, "_out_valid"}, {31'd0, out_valid_c}, 32'd0);
    check({pfx, "_out_data"},  {16'd0, out_data_c},  32'd0);
    check({pfx, "_out_sat"},   {31'd0, out_sat_c},   32'd0);
    check({pfx, "_busy"},      {31'd0, busy_c},      32'd0);
    check({pfx, "_done"},      {31'd0, done_c},      32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // All-ones kernel over a 0..24 ramp; a RUN-time coef write and start are injected.
    for (int i = 0; i < 25; i++) pix[i] = 8'(i);
    for (int k = 0; k < 9; k++) cf[k] = 8'd1;
    load_coefs();
    run_frame(-1, 6, -1, 1'b1);

    // Identity kernel.
    for (int k = 0; k < 9; k++) cf[k] = 8'd0;
    cf[4] = 8'd1;
    load_coefs();
    run_frame(-1, -1, -1, 1'b1);

    // Unsigned saturation.
    for (int i = 0; i < 25; i++) pix[i] = 8'd255;
    for (int k = 0; k < 9; k++) cf[k] = 8'd255;
    load_coefs();
    run_frame(-1, -1, -1, 1'b1);

    // Signed instance: -1 kernel over constant 10.
    use_s = 1'b1;
    for (int i = 0; i < 25; i++) pix[i] = 8'd10;
    for (int k = 0; k < 9; k++) cf[k] = 8'hFF;
    load_coefs();
    run_frame(-1, -1, -1, 1'b1);
    use_s = 1'b0;

    // Backpressure mid-frame.
    for (int i = 0; i < 25; i++) pix[i] = 8'(i);
    for (int k = 0; k < 9; k++) cf[k] = 8'd1;
    load_coefs();
    run_frame(14, -1, -1, 1'b1);

    // Abort after 12 accepted pixels.
    run_frame(-1, -1, 12, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_output", {31'd0, out_valid_c}, 32'd0);

    // Coefficients were cleared by reset: all-ones frame gives zeros.
    for (int i = 0; i < 25; i++) pix[i] = 8'd1;
    for (int k = 0; k < 9; k++) cf[k] = 8'd0;
    run_frame(-1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
